// File: rtl/gtxe2_rx_align_pkg.sv
// gtxe2_rx_align_pkg
// Shared definitions for the GTXE2 RX comma-alignment stage: the default
// K28.5 comma patterns, the alignment FSM state type, the offset width and
// small helpers that map a comma position onto an alignment offset.
//
// Optional feature macro: GTXE2_RX_ALIGN_COMMA_DOUBLE_EN
//   defined   - commas are aligned into the low symbol only (offset 0..19)
//   undefined - commas may sit in either symbol (offset 0..9)
package gtxe2_rx_align_pkg;

  localparam logic [9:0] PCOMMA_DEFAULT = 10'b0101111100;
  localparam logic [9:0] MCOMMA_DEFAULT = 10'b1010000011;

  localparam int OFF_W = 5;
  localparam int SYM_W = 10;
  localparam int NPOS  = 20;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } rx_align_state_t;

  // Map the bit position of a comma inside the history window to the shift
  // that puts it on a symbol boundary of the output word.
  function automatic logic [OFF_W-1:0] fold_offset(input logic [OFF_W-1:0] p);
`ifdef GTXE2_RX_ALIGN_COMMA_DOUBLE_EN
    return p;
`else
    return (p >= 5'd10) ? (p - 5'd10) : p;
`endif
  endfunction

  // True when the output word taken at offset o holds a comma on a symbol
  // boundary. Only the low symbol counts when double-symbol alignment is on.
  function automatic logic comma_at(input logic [NPOS-1:0] vec,
                                    input logic [OFF_W-1:0] o);
`ifdef GTXE2_RX_ALIGN_COMMA_DOUBLE_EN
    return vec[o];
`else
    return vec[o] | ((o < 5'd10) && vec[o + 5'd10]);
`endif
  endfunction

endpackage

// File: rtl/gtxe2_chnl_rx_comma_det.sv
// gtxe2_chnl_rx_comma_det
// Combinational comma search over the 40-bit history window. Every one of
// the 20 possible bit positions is checked against both comma patterns.
//
// Ports:
//   win            in  29  history bits [28:0] (all windows p = 0..19)
//   pcommaalignen  in  1   plus-comma may trigger realignment
//   mcommaalignen  in  1   minus-comma may trigger realignment
//   match_vec      out 20  enabled comma found at position p
//   comma_vec      out 20  comma of either polarity at p, enables ignored
//   first_idx      out 5   lowest position with an enabled match
//   first_valid    out 1   first_idx is meaningful
module gtxe2_chnl_rx_comma_det
  import gtxe2_rx_align_pkg::*;
#(
  parameter logic [9:0] pcomma = PCOMMA_DEFAULT,
  parameter logic [9:0] mcomma = MCOMMA_DEFAULT
) (
  input  logic [28:0]      win,
  input  logic             pcommaalignen,
  input  logic             mcommaalignen,
  output logic [NPOS-1:0]  match_vec,
  output logic [NPOS-1:0]  comma_vec,
  output logic [OFF_W-1:0] first_idx,
  output logic             first_valid
);

  always_comb begin
    match_vec = '0;
    comma_vec = '0;
    for (int p = 0; p < NPOS; p++) begin
      comma_vec[p] = (win[p +: SYM_W] == pcomma) || (win[p +: SYM_W] == mcomma);
      match_vec[p] = (pcommaalignen && (win[p +: SYM_W] == pcomma)) ||
                     (mcommaalignen && (win[p +: SYM_W] == mcomma));
    end
  end

  // Scanning from the top down lets the lowest matching position win.
  always_comb begin
    first_idx   = '0;
    first_valid = 1'b0;
    for (int p = NPOS - 1; p >= 0; p--) begin
      if (match_vec[p]) begin
        first_idx   = OFF_W'(p);
        first_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gtxe2_chnl_rx_align.sv
// gtxe2_chnl_rx_align
// Comma detection and byte alignment for the GTXE2 RX channel model. The
// raw deserializer words are kept in a two-word history; K28.5 commas are
// searched at every bit offset and the output word is barrel-shifted so
// commas land on a 10-bit symbol boundary. Latency indata->outdata is two
// usrclk cycles regardless of the offset in use.
//
// Ports:
//   usrclk         in  1   clock
//   reset          in  1   asynchronous, active-high reset
//   indata         in  20  raw deserialized word
//   commadeten     in  1   comma detection enable; low freezes alignment
//   pcommaalignen  in  1   allow realignment on the plus comma
//   mcommaalignen  in  1   allow realignment on the minus comma
//   outdata        out 20  aligned word
//   realign        out 1   pulse with the first word at a new offset
//   aligned        out 1   lock indicator (BYTEISALIGNED equivalent)
//   comma_det      out 1   outdata holds a comma on a symbol boundary
//
// Optional feature macro: GTXE2_RX_ALIGN_COMMA_DOUBLE_EN (low-symbol-only
// alignment, offsets 0..19).
module gtxe2_chnl_rx_align
  import gtxe2_rx_align_pkg::*;
#(
  parameter int         width      = 20,
  parameter logic [9:0] pcomma     = PCOMMA_DEFAULT,
  parameter logic [9:0] mcomma     = MCOMMA_DEFAULT,
  parameter int         loss_words = 255
) (
  input  logic             usrclk,
  input  logic             reset,
  input  logic [width-1:0] indata,
  input  logic             commadeten,
  input  logic             pcommaalignen,
  input  logic             mcommaalignen,
  output logic [width-1:0] outdata,
  output logic             realign,
  output logic             aligned,
  output logic             comma_det
);

  localparam logic [15:0] LOSS_LIMIT = 16'(loss_words);

  logic [2*width-1:0] hist;
  rx_align_state_t    state, state_nxt;
  logic [OFF_W-1:0]   off, off_nxt, first_idx, tgt;
  logic [15:0]        loss_cnt, loss_cnt_nxt, loss_cnt_inc;
  logic [NPOS-1:0]    match_vec, comma_vec;
  logic               first_valid, cur_comma;
  logic               aligned_nxt, realign_nxt;
  logic               match_vec_unused;

  gtxe2_chnl_rx_comma_det #(
    .pcomma (pcomma),
    .mcomma (mcomma)
  ) u_comma_det (
    .win           (hist[28:0]),
    .pcommaalignen (pcommaalignen),
    .mcommaalignen (mcommaalignen),
    .match_vec     (match_vec),
    .comma_vec     (comma_vec),
    .first_idx     (first_idx),
    .first_valid   (first_valid)
  );

  // The per-position enabled matches are already summarised by first_idx.
  assign match_vec_unused = ^match_vec;

  assign tgt          = fold_offset(first_idx);
  assign cur_comma    = comma_at(comma_vec, off);
  assign loss_cnt_inc = loss_cnt + 16'd1;

  // A new enabled comma always takes priority over loss counting, so a comma
  // arriving in the same cycle the counter expires keeps the block locked.
  always_comb begin
    state_nxt    = state;
    off_nxt      = off;
    loss_cnt_nxt = loss_cnt;
    aligned_nxt  = aligned;
    realign_nxt  = 1'b0;
    if (commadeten) begin
      if (first_valid && ((state == SEARCH) || (tgt != off))) begin
        off_nxt      = tgt;
        realign_nxt  = 1'b1;
        state_nxt    = LOCKED;
        loss_cnt_nxt = '0;
      end else if (state == LOCKED) begin
        if (cur_comma) begin
          loss_cnt_nxt = '0;
          aligned_nxt  = 1'b1;
        end else if (loss_cnt_inc == LOSS_LIMIT) begin
          state_nxt    = SEARCH;
          aligned_nxt  = 1'b0;
          loss_cnt_nxt = '0;
        end else begin
          loss_cnt_nxt = loss_cnt_inc;
        end
      end
    end
  end

  // The output word is cut from the history with the offset that takes
  // effect this cycle, so realign lines up with the first shifted word and
  // no cycle is dropped or repeated when the offset moves.
  always_ff @(posedge usrclk or posedge reset) begin
    if (reset) begin
      hist      <= '0;
      state     <= SEARCH;
      off       <= '0;
      loss_cnt  <= '0;
      aligned   <= 1'b0;
      realign   <= 1'b0;
      comma_det <= 1'b0;
      outdata   <= '0;
    end else begin
      hist      <= {indata, hist[2*width-1:width]};
      state     <= state_nxt;
      off       <= off_nxt;
      loss_cnt  <= loss_cnt_nxt;
      aligned   <= aligned_nxt;
      realign   <= realign_nxt;
      comma_det <= commadeten & comma_at(comma_vec, off_nxt);
      outdata   <= hist[{1'b0, off_nxt} +: width];
    end
  end

endmodule

// File: tb/tb_gtxe2_chnl_rx_align.sv
// tb_gtxe2_chnl_rx_align
// Scoreboard bench for gtxe2_chnl_rx_align (default build). The stimulus
// side builds a bit stream of 10-bit symbols, feeds it 20 bits at a time and
// pushes the response predicted by a stream-level reference model; a
// separate monitor pops one entry per clock and compares.
module tb_gtxe2_chnl_rx_align;

  localparam logic [9:0]  PC   = 10'b0101111100;
  localparam logic [9:0]  MC   = 10'b1010000011;
  localparam logic [9:0]  FILL = 10'b1010101010;
  localparam int          LOSS = 4;

  logic        usrclk = 1'b0;
  logic        reset;
  logic [19:0] indata;
  logic        commadeten, pcommaalignen, mcommaalignen;
  logic [19:0] outdata;
  logic        realign, aligned, comma_det;

  gtxe2_chnl_rx_align #(
    .loss_words (LOSS)
  ) dut (
    .usrclk        (usrclk),
    .reset         (reset),
    .indata        (indata),
    .commadeten    (commadeten),
    .pcommaalignen (pcommaalignen),
    .mcommaalignen (mcommaalignen),
    .outdata       (outdata),
    .realign       (realign),
    .aligned       (aligned),
    .comma_det     (comma_det)
  );

  always #5 usrclk = ~usrclk;

  typedef struct packed {
    logic [19:0] data;
    logic        realign;
    logic        aligned;
    logic        comma_det;
  } exp_t;

  exp_t sbq[$];
  bit   bitq[$];
  int   total = 0;
  int   bad   = 0;
  int   sym_cnt = 0;

  // Reference model: the last two fed words, lock flag, offset, loss count.
  logic [19:0] m_lo, m_hi;
  bit          m_locked, m_aligned;
  int          m_off, m_cnt;

  task automatic checkOutput(input string name, input logic [19:0] act,
                             input logic [19:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %05h expected %05h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit has_comma(input logic [39:0] w, input int pos,
                                   input logic [9:0] pat);
    logic [39:0] s;
    s = w >> pos;
    return s[9:0] == pat;
  endfunction

  function automatic bit sym_comma(input logic [39:0] w, input int o);
    return has_comma(w, o, PC) || has_comma(w, o, MC) ||
           has_comma(w, o + 10, PC) || has_comma(w, o + 10, MC);
  endfunction

  task automatic model_reset();
    m_lo = '0; m_hi = '0;
    m_locked = 0; m_aligned = 0; m_off = 0; m_cnt = 0;
  endtask

  // One clock of the model: the comma search covers the 20 start positions of
  // the older word inside the two most recent words; the newest word only
  // enters the window on the following clock.
  task automatic model_step(input logic [19:0] w_new, output exp_t e);
    logic [39:0] win;
    int fp;
    bit rl;
    win = {m_hi, m_lo};
    fp = -1;
    for (int p = 19; p >= 0; p--)
      if ((pcommaalignen && has_comma(win, p, PC)) || (mcommaalignen && has_comma(win, p, MC)))
        fp = p;
    rl = 0;
    if (commadeten) begin
      if (fp >= 0 && (!m_locked || (fp % 10) != m_off)) begin
        m_off = fp % 10; rl = 1; m_locked = 1; m_cnt = 0;
      end else if (m_locked && sym_comma(win, m_off)) begin
        m_cnt = 0; m_aligned = 1;
      end else if (m_locked) begin
        m_cnt++;
        if (m_cnt == LOSS) begin
          m_locked = 0; m_aligned = 0; m_cnt = 0;
        end
      end
    end
    e.data      = 20'(win >> m_off);
    e.realign   = rl;
    e.aligned   = m_aligned;
    e.comma_det = commadeten && sym_comma(win, m_off);
    m_lo = m_hi;
    m_hi = w_new;
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int j = 0; j < 10; j++) bitq.push_back(s[j]);
  endtask

  task automatic push_bits(input int n);
    for (int j = 0; j < n; j++) bitq.push_back(j[0]);
  endtask

  task automatic gen_symbol(input int mode);
    int r;
    case (mode)
      0: push_sym(FILL);
      1: push_sym((sym_cnt % 4 == 0) ? PC : FILL);
      2: push_sym((sym_cnt % 4 == 0) ? MC : FILL);
      default: begin
        r = $urandom_range(0, 5);
        if (r == 0)      push_sym(PC);
        else if (r == 1) push_sym(MC);
        else             push_sym(10'($urandom));
        if ($urandom_range(0, 30) == 0) push_bits($urandom_range(1, 9));
      end
    endcase
    sym_cnt++;
  endtask

  // Drive one word per clock from the symbol stream; called at a negedge.
  task automatic applyStimulus(input int n_words, input int mode);
    logic [19:0] w;
    exp_t e;
    for (int i = 0; i < n_words; i++) begin
      while (bitq.size() < 20) gen_symbol(mode);
      for (int j = 0; j < 20; j++) w[j] = bitq.pop_front();
      if (mode == 3 && $urandom_range(0, 15) == 0) begin
        pcommaalignen = 1'($urandom);
        mcommaalignen = 1'($urandom);
        commadeten    = ($urandom_range(0, 7) != 0);
      end
      indata = w;
      model_step(w, e);
      sbq.push_back(e);
      @(negedge usrclk);
    end
  endtask

  // Monitor: every clock has an output word; compare it with the oldest
  // prediction whenever one is pending.
  always @(posedge usrclk) begin
    exp_t me;
    #1;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      checkOutput("outdata",   outdata,          me.data);
      checkOutput("realign",   20'(realign),     20'(me.realign));
      checkOutput("aligned",   20'(aligned),     20'(me.aligned));
      checkOutput("comma_det", 20'(comma_det),   20'(me.comma_det));
    end
  end

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_outdata"},   outdata,         20'd0);
    checkOutput({tag, "_realign"},   20'(realign),    20'd0);
    checkOutput({tag, "_aligned"},   20'(aligned),    20'd0);
    checkOutput({tag, "_comma_det"}, 20'(comma_det),  20'd0);
  endtask

  initial begin
    reset = 1'b1;
    indata = '0;
    commadeten = 1'b1;
    pcommaalignen = 1'b1;
    mcommaalignen = 1'b1;
    repeat (2) @(negedge usrclk);
    check_reset_outputs("por");
    reset = 1'b0;
    model_reset();

    $display("[TB] pcomma at bit 7 after reset");
    push_bits(7);
    applyStimulus(16, 1);

    $display("[TB] stream shifted by 4 bits while locked");
    push_bits(4);
    applyStimulus(12, 1);

    $display("[TB] mcomma at bit 13, upper symbol");
    push_bits(2);
    applyStimulus(12, 2);

    $display("[TB] commas stop, loss of lock, then relock");
    applyStimulus(10, 0);
    applyStimulus(8, 2);

    $display("[TB] plus-comma alignment disabled, new offset");
    pcommaalignen = 1'b0;
    push_bits(5);
    applyStimulus(12, 1);
    commadeten = 1'b0;
    applyStimulus(8, 1);
    commadeten = 1'b1;
    pcommaalignen = 1'b1;
    applyStimulus(8, 1);

    $display("[TB] asynchronous reset while locked");
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid");
    repeat (2) @(negedge usrclk);
    reset = 1'b0;
    model_reset();
    bitq.delete();
    sym_cnt = 0;
    push_bits(3);
    applyStimulus(12, 1);

    $display("[TB] randomized stream");
    applyStimulus(400, 3);
    commadeten = 1'b1;
    pcommaalignen = 1'b1;
    mcommaalignen = 1'b1;

    @(posedge usrclk);
    #2;
    checkOutput("sb_drain", 20'(sbq.size()), 20'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gtxe2_chnl_rx_align.md
# gtxe2_chnl_rx_align

Comma detection and byte-alignment stage of the GTXE2 channel RX model, running in the `usrclk` domain. It takes the raw 20-bit word stream from the deserializer, finds K28.5 commas at any bit offset, and barrel-shifts the stream so that commas land on a 10-bit symbol boundary. It outputs aligned words plus a `realign` pulse. Its outputs feed the 8b/10b decoder, and the `realign` pulse propagates to the RX data interface, where it restarts the word counter.

## Interface
- `width`, 20: raw and aligned word width; fixed at two 10-bit symbols.
- `pcomma`, 10'b0101111100: plus-comma pattern, compared LSB-first against a 10-bit window.
- `mcomma`, 10'b1010000011: minus-comma pattern.
- `loss_words`, 255: consecutive words without a comma at the current offset before lock is dropped; range 1..65535.

Ports:
- `usrclk`  in  1  sole clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `indata`  in  20  raw deserialized word.
- `commadeten`  in  1  enables comma detection; when low, no state changes occur and `comma_det` stays 0.
- `pcommaalignen`  in  1  allows realignment on `pcomma`.
- `mcommaalignen`  in  1  allows realignment on `mcomma`.
- `outdata`  out  20  aligned word.
- `realign`  out  1  one-cycle pulse; it coincides with the first `outdata` word at a new offset.
- `aligned`  out  1  lock indicator (BYTEISALIGNED equivalent).
- `comma_det`  out  1  set when the current `outdata` contains a comma at a symbol boundary.

## Operation
- **History register:** `hist[39:0]` is updated every cycle as `{indata, hist[39:20]}`.
- **Match vector:** for each p = 0..19, `m[p]` = `hist[p+9:p]` equals `pcomma` (if `pcommaalignen`) or `mcomma` (if `mcommaalignen`). When several bits are set, the lowest p wins.
- **Target offset:** default target offset is p mod 10. Under the macro (see Configuration), the target offset is p.
- **Offset register:** `off`, 5 bits, reset value 0. The output word is `hist[off+19:off]`.
- **States:** `SEARCH` (reset state) and `LOCKED`.
  - `SEARCH`: on any enabled match, load `off` with the target offset, pulse `realign`, and go to `LOCKED`.
  - `LOCKED`, enabled match with target offset ≠ `off`: reload `off`, pulse `realign`, stay in `LOCKED`.
  - `LOCKED`, comma of either polarity at the current offset (independent of the align enables): clear the loss counter.
  - `LOCKED`, otherwise: increment the loss counter. When it reaches `loss_words`, go to `SEARCH`, set `aligned` to 0 and clear the counter.
- **`aligned`:** set to 1 on the first comma seen at the current offset while in `LOCKED`. It is not set by the realign word alone.
- **`commadeten` low:** `off`, the state and the counter all hold, and `outdata` keeps flowing at the current offset.
- **Both align enables low:** no realignment happens. Loss counting continues.

## Timing
- **Latency:** 2 `usrclk` cycles from `indata` to `outdata`, constant. Changing `off` never drops or duplicates a cycle; bits in the shifted-out window are discarded.
- **`realign` timing:** `realign` is registered with `outdata`. It is high exactly in the cycle whose `outdata` holds the comma in bits [9:0] (macro) or in [9:0] or [19:10] (default).
- **Reset values:** `outdata` = 0, `realign` = 0, `aligned` = 0, `comma_det` = 0, `off` = 0, state = `SEARCH`, loss counter = 0, `hist` = 0.
- **Reset asserted mid-stream:** all state clears immediately. The first valid `outdata` appears 2 cycles after deassertion.
- **Back-to-back commas at different offsets:** each one produces its own `realign` pulse.
- **Loss of lock and a new comma in the same cycle:** the match wins, so the block realigns and stays `LOCKED`.

## Configuration
- Macro: `GTXE2_RX_ALIGN_COMMA_DOUBLE_EN`.
  - Defined: commas align only into `outdata[9:0]` (offset 0..19). A comma already in [19:10] forces a realign.
  - Undefined: commas align into either symbol (offset 0..9). A comma in [19:10] counts as aligned.

## Structure
- Package `gtxe2_rx_align_pkg`:
  - default comma constants;
  - `rx_align_state_t` enum (`SEARCH`, `LOCKED`);
  - offset width constant (5).
- Sub-module `gtxe2_chnl_rx_comma_det` is combinational. It produces the 20-bit match vector from `hist` plus a priority-encoded first-match index with a valid flag. The top level holds the history, the offset, the FSM, the counter and the output registers.

## Test plan
- **Comma at offset 7 after reset:** feed a stream with `pcomma` at bit 7 of a word.
  - Required: `realign` pulses once.
  - `outdata[9:0]` = `pcomma` 2 cycles after the matching `indata`.
  - `aligned` goes to 1 on the next comma at the same offset.
- **Comma found in the upper symbol:** `mcomma` at p = 13, `mcommaalignen` = 1.
  - Default build: `off` = 3, comma in `outdata[19:10]`.
  - Macro build: `off` = 13, comma in [9:0].
- **Offset shift while locked:** shift the stream by 4 bits.
  - Required: one `realign` pulse, new `off` applied, no cycle gap on `outdata`.
- **Loss of lock:** `loss_words` = 4; after lock, stop sending commas.
  - Required: `aligned` drops after exactly 4 words, state returns to `SEARCH`.
  - The next comma produces a `realign` pulse.
- **Disabled alignment:** `pcommaalignen` = 0, `pcomma` only at a new offset.
  - Required: no `realign`, `off` unchanged.
  - With `commadeten` = 0: `comma_det` stays 0.
- **Reset mid-stream:** assert `reset` asynchronously while `LOCKED`.
  - Required: all outputs read 0 before the next edge, state is `SEARCH`.
  - Relock occurs on the first comma after release.
